// File: rtl/fxp_avg_addsub_pkg.sv
// Shared vector fixed-point definitions: averaging op codes, SEW and vxrm
// encodings, used by the add/sub front end and the rounding stage.
package fxp_avg_addsub_pkg;

  typedef enum logic [1:0] {
    OP_VAADDU = 2'b00,
    OP_VAADD  = 2'b01,
    OP_VASUBU = 2'b10,
    OP_VASUB  = 2'b11
  } avg_op_e;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10,
    SEW64 = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    VXRM_RNU = 2'b00,
    VXRM_RNE = 2'b01,
    VXRM_RDN = 2'b10,
    VXRM_ROD = 2'b11
  } vxrm_e;

  // op[0] selects signed interpretation, op[1] selects subtraction
  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_sub(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic int unsigned sew_bits(input logic [1:0] sew);
    return 32'd8 << sew;
  endfunction

endpackage

// File: rtl/fxp_avg_addsub_extend.sv
// Combinational SEW-width element extension to DATA_WIDTH+1 bits; bits above
// the element are replaced by the sign (signed) or zero (unsigned).
module fxp_extend
  import fxp_avg_addsub_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            sew,
  input  logic                  sgn,
  output logic [DATA_WIDTH:0]   ext
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  int unsigned     w;
  logic [IW-1:0]   msb_idx;
  logic            fill;

  // Element width is clamped so narrow datapaths still see a valid MSB
  always_comb begin
    w = sew_bits(sew);
    if (w > DATA_WIDTH) w = DATA_WIDTH;
    msb_idx = IW'(w - 1);
    fill    = sgn & data[msb_idx];
  end

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
    assign ext[gi] = (gi < w) ? data[gi] : fill;
  end
  assign ext[DATA_WIDTH] = fill;

endmodule

// File: rtl/fxp_avg_addsub.sv
// Averaging add/sub front end: S1 extends operands, S2 forms the unshifted
// DATA_WIDTH+1 sum/difference handed to the rounding stage.
module fxp_avg_addsub
  import fxp_avg_addsub_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] vs2,
  input  logic [DATA_WIDTH-1:0] vs1,
  input  logic [1:0]            op,
  input  logic [1:0]            sew,
  input  logic [1:0]            vxrm_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   result_out,
  output logic [1:0]            vxrm_out,
  output logic [1:0]            sew_out
);

  logic [DATA_WIDTH:0] ext_a, ext_b;
  logic [DATA_WIDTH:0] s1_a, s1_b;
  logic [1:0]          s1_op, s1_sew, s1_vxrm;
  logic                s1_valid;
  logic                s2_free;
  logic                s1_sub;
  logic [DATA_WIDTH:0] s2_d;

  fxp_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext_a (
    .data (vs2),
    .sew  (sew),
    .sgn  (op_is_signed(op)),
    .ext  (ext_a)
  );

  fxp_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext_b (
    .data (vs1),
    .sew  (sew),
    .sgn  (op_is_signed(op)),
    .ext  (ext_b)
  );

  // S2 slot can take a beat when empty or being drained this cycle
  assign s2_free  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_free;

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else if (in_ready) s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_a    <= ext_a;
      s1_b    <= ext_b;
      s1_op   <= op;
      s1_sew  <= sew;
      s1_vxrm <= vxrm_in;
    end
  end

  // Single adder: subtraction as A + ~B + 1
  assign s1_sub = op_is_sub(s1_op);
  assign s2_d   = s1_a + (s1_b ^ {(DATA_WIDTH+1){s1_sub}})
                + {{DATA_WIDTH{1'b0}}, s1_sub};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result_out <= '0;
      vxrm_out   <= '0;
      sew_out    <= '0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result_out <= s2_d;
        vxrm_out   <= s1_vxrm;
        sew_out    <= s1_sew;
      end
    end
  end

endmodule

// File: tb/tb_fxp_avg_addsub.sv
// Directed and scoreboarded checks of the averaging add/sub front end.
module tb_fxp_avg_addsub;
  import fxp_avg_addsub_pkg::*;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] vs2, vs1;
  logic [1:0]    op, sew, vxrm_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW:0]   result_out;
  logic [1:0]    vxrm_out, sew_out;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [DW:0] res;
    logic [1:0]  vxrm;
    logic [1:0]  sew;
  } exp_t;

  exp_t q[$];

  fxp_avg_addsub #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vs2        (vs2),
    .vs1        (vs1),
    .op         (op),
    .sew        (sew),
    .vxrm_in    (vxrm_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out),
    .vxrm_out   (vxrm_out),
    .sew_out    (sew_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: mask to element, then subtract 2^n when a signed element is negative
  function automatic logic [DW:0] model(input logic [1:0] mop, input logic [1:0] msew,
                                        input logic [DW-1:0] a, input logic [DW-1:0] b);
    int unsigned n;
    logic [DW-1:0] one, mask, ta, tb;
    logic signed [DW+1:0] one_w, ea, eb, r;
    n     = 8 << msew;
    one   = 1;
    one_w = 1;
    mask  = (n >= DW) ? '1 : ((one << n) - one);
    ea    = {2'b00, a & mask};
    eb    = {2'b00, b & mask};
    ta    = a >> (n - 1);
    tb    = b >> (n - 1);
    if (mop[0] && ta[0]) ea = ea - (one_w << n);
    if (mop[0] && tb[0]) eb = eb - (one_w << n);
    r = mop[1] ? (ea - eb) : (ea + eb);
    return r[DW:0];
  endfunction

  task automatic send_one(input string tag, input logic [1:0] o, input logic [1:0] s,
                          input logic [1:0] x, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW:0] expv);
    op = o; sew = s; vxrm_in = x; vs2 = a; vs1 = b;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, out_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_result"}, result_out, expv);
    chk({tag, "_vxrm"}, vxrm_out, x);
    chk({tag, "_sew"}, sew_out, s);
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    op = OP_VAADD; sew = SEW8; vxrm_in = VXRM_ROD; vs2 = 64'h5; vs1 = 64'h3;
    repeat (3) tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result_out, '0);
    chk("rst_vxrm", vxrm_out, 2'b00);
    chk("rst_sew", sew_out, 2'b00);
    chk("rst_in_ready", in_ready, 1'b1);
    tick();
    chk("rst_ignore1", out_valid, 1'b0);
    tick();
    chk("rst_ignore2", out_valid, 1'b0);

    send_one("vaadd8",  OP_VAADD,  SEW8,  VXRM_RNU, 64'h7F, 64'h01, 65'h0_0000_0000_0000_0080);
    send_one("vasub8",  OP_VASUB,  SEW8,  VXRM_RNE, 64'h80, 64'h7F, 65'h1_FFFF_FFFF_FFFF_FF01);
    send_one("vaaddu64", OP_VAADDU, SEW64, VXRM_RDN, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE);
    send_one("vasubu16", OP_VASUBU, SEW16, VXRM_ROD, 64'h0, 64'h1, 65'h1_FFFF_FFFF_FFFF_FFFF);
    send_one("upper_ign", OP_VAADDU, SEW8, VXRM_RNU, 64'hFFFF_FFFF_FFFF_FF80,
             64'hAAAA_AAAA_AAAA_AA80, 65'h0_0000_0000_0000_0100);
    send_one("vasub32", OP_VASUB, SEW32, VXRM_RDN, 64'h1234_0000_0000_0005, 64'h7,
             65'h1_FFFF_FFFF_FFFF_FFFE);

    // Back-pressure: beats 1,2,3 with downstream stalling from the third cycle
    op = OP_VAADDU; sew = SEW8; vxrm_in = VXRM_RNU; vs1 = 64'h0;
    in_valid = 1'b1; out_ready = 1'b1; vs2 = 64'd1;
    #1; chk("bp_rdy_b1", in_ready, 1'b1);
    tick();
    vs2 = 64'd2;
    #1; chk("bp_rdy_b2", in_ready, 1'b1);
    tick();
    vs2 = 64'd3; out_ready = 1'b0;
    #1;
    chk("bp_rdy_full", in_ready, 1'b0);
    chk("bp_valid_b1", out_valid, 1'b1);
    chk("bp_res_b1", result_out, 65'd1);
    tick();
    chk("bp_rdy_hold", in_ready, 1'b0);
    chk("bp_hold_b1a", result_out, 65'd1);
    tick();
    chk("bp_hold_b1b", result_out, 65'd1);
    chk("bp_hold_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    #1; chk("bp_rdy_drain", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_valid_b2", out_valid, 1'b1);
    chk("bp_res_b2", result_out, 65'd2);
    tick();
    chk("bp_valid_b3", out_valid, 1'b1);
    chk("bp_res_b3", result_out, 65'd3);
    tick();
    chk("bp_empty", out_valid, 1'b0);

    // Reset with two beats in flight
    in_valid = 1'b1; vs2 = 64'd9;
    tick();
    vs2 = 64'd10;
    tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_result", result_out, '0);
    chk("mid_rst_ready", in_ready, 1'b1);
    tick();
    chk("mid_rst_flush", out_valid, 1'b0);
    send_one("post_rst", OP_VAADD, SEW16, VXRM_RNE, 64'hFFFF, 64'h0002, 65'h0_0000_0000_0000_0001);

    // Random stream against the reference queue
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      op = 2'($urandom); sew = 2'($urandom); vxrm_in = 2'($urandom);
      vs2 = {$urandom, $urandom}; vs1 = {$urandom, $urandom};
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_spurious", out_valid, 1'b0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_result", result_out, e.res);
          chk("sb_vxrm", vxrm_out, e.vxrm);
          chk("sb_sew", sew_out, e.sew);
        end
      end
      if (in_valid && in_ready) q.push_back('{model(op, sew, vs2, vs1), vxrm_in, sew});
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int g = 0; g < 20 && q.size() > 0; g++) begin
      #1;
      if (out_valid) begin
        exp_t e;
        e = q.pop_front();
        chk("sb_drain_result", result_out, e.res);
        chk("sb_drain_vxrm", vxrm_out, e.vxrm);
        chk("sb_drain_sew", sew_out, e.sew);
      end
      tick();
    end
    chk("sb_left", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fxp_avg_addsub.md
FXP_AVG_ADDSUB -- requirements
Module: fxp_avg_addsub

Interface
REQ-001 Parameter DATA_WIDTH, default 64; element datapath width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  operand beat offered.
REQ-005 in_ready  out  1  block accepts beat this cycle.
REQ-006 vs2  in  DATA_WIDTH  operand A; element in low SEW bits.
REQ-007 vs1  in  DATA_WIDTH  operand B; element in low SEW bits.
REQ-008 op  in  2  00 vaaddu, 01 vaadd, 10 vasubu, 11 vasub.
REQ-009 sew  in  2  00=8, 01=16, 10=32, 11=64 bits.
REQ-010 vxrm_in  in  2  rounding mode, carried as sideband.
REQ-011 out_valid  out  1  result beat present.
REQ-012 out_ready  in  1  downstream accepts beat; rounding stage ties high.
REQ-013 result_out  out  DATA_WIDTH+1  unshifted sum/difference for the rounding stage.
REQ-014 vxrm_out, sew_out  out  2 each  sideband aligned with result_out.

Function
REQ-015 Beat accepted when in_valid & in_ready; result presented when out_valid & out_ready.
REQ-016 Two-stage pipeline: S1 registers extended operands, op, sew, vxrm; S2 registers result and sideband.
REQ-017 Latency SHALL be 2 cycles from accept to out_valid with no stall; throughput 1 beat/cycle.
REQ-018 S1 extension: signed ops (vaadd, vasub) sign-extend bit SEW-1 to DATA_WIDTH+1 bits; unsigned ops zero-extend; bits above SEW-1 of vs2/vs1 ignored.
REQ-019 S2 computes A+B (add ops) or A-B (sub ops) modulo 2^(DATA_WIDTH+1), two's complement; no saturation, no overflow flag.
REQ-020 vasubu result SHALL be the signed DATA_WIDTH+1 difference of zero-extended operands.
REQ-021 Stall: stage advances iff downstream slot empty or being drained same cycle; in_ready = ~S1_valid | S1_advances.
REQ-022 in_ready combinational from pipeline valids and out_ready only, never from in_valid.
REQ-023 Stalled S2 SHALL hold result_out and sideband stable while out_valid & ~out_ready.
REQ-024 Simultaneous accept and drain with full pipe SHALL lose no beat and insert no bubble.
REQ-025 Data registers without valid need no defined value, but result_out SHALL be 0 after reset.

Reset
REQ-026 On rst: S1_valid=0, out_valid=0, result_out=0, vxrm_out=0, sew_out=0; in_ready=1 the cycle after.
REQ-027 rst mid-operation SHALL discard in-flight beats; no out_valid on the cycle following rst.
REQ-028 in_valid during rst SHALL be ignored.

Structure
REQ-029 Op encodings, SEW encodings, and vxrm enum SHALL live in the shared vector fixed-point package, used also by the rounding stage.
REQ-030 One sub-module natural: fxp_extend (combinational SEW/sign extension to DATA_WIDTH+1), instantiated twice in S1.
REQ-031 Implementation SHALL be 120-400 lines RTL; no multipliers, single adder/subtractor.

Verification
REQ-032 vaadd, SEW8, vs2=0x7F, vs1=0x01, out_ready=1 -> out_valid two cycles later, result_out=0x0_0000_0000_0000_0080.
REQ-033 vasub, SEW8, vs2=0x80, vs1=0x7F -> result_out=0x1_FFFF_FFFF_FFFF_FF01 (-255).
REQ-034 vaaddu, SEW64, vs2=vs1=0xFFFF_FFFF_FFFF_FFFF -> result_out=0x1_FFFF_FFFF_FFFF_FFFE; vasubu SEW16 vs2=0x0000, vs1=0x0001 -> 0x1_FFFF_FFFF_FFFF_FFFF.
REQ-035 Back-to-back beats 1,2,3 with out_ready=0 from cycle 2 -> in_ready falls after two beats held; beat 1 stable on result_out; out_ready=1 drains 1,2,3 in order, no loss/duplicates.
REQ-036 rst asserted with two beats in flight -> out_valid=0, result_out=0 next cycle; new beat after rst emerges 2 cycles after accept.
REQ-037 Random op/sew/vxrm stream with random out_ready vs scoreboard model -> all results and vxrm_out/sew_out match.
